// File: rtl/intc_hwint.sv
// intc_hwint: memory-mapped interrupt controller producing the CPU hwInt vector.
//
// Each source is sampled into s_q_r and latched into pend_r. A bit in edge mode
// latches on a rising edge and clears on a write-1-to-clear. A bit in level mode
// follows s_q_r. The block registers hw_int = pend & mask, and ID reports the
// lowest-numbered pending and enabled source.
//
// Optional feature macro: INTC_SYNC_EN. Defining it places a two-flop
// synchronizer (sync1_r -> s_q_r) ahead of the edge detector so that sources
// from other clock domains can be used. When it is not defined, src is sampled
// by a single flop and must be synchronous to clk.
//
// Register map (addr[3:2]): 0 PEND (R/W1C), 1 MASK (R/W), 2 EDGE (R/W), 3 ID (RO).
// NSRC must be in the range 1..16.

module intc_hwint #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            sel,
    input  logic [3:0]      addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [NSRC-1:0] hw_int
);

`ifdef INTC_SYNC_EN
    localparam logic [1:0] PRIME_CYC = 2'd2;
`else
    localparam logic [1:0] PRIME_CYC = 2'd1;
`endif

    // Index of the lowest set bit, or all-ones when no bit is set.
    function automatic logic [31:0] find_id(input logic [NSRC-1:0] v);
        logic [31:0] id;
        id = 32'hFFFF_FFFF;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                id = 32'(i);
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    logic [NSRC-1:0] s_in_s;
    logic [NSRC-1:0] s_q_r;
    logic [NSRC-1:0] s_prev_r;
    logic [NSRC-1:0] pend_r;
    logic [NSRC-1:0] pend_nxt_s;
    logic [NSRC-1:0] mask_r;
    logic [NSRC-1:0] edge_r;
    logic [1:0]      prime_cnt_r;
    logic            primed_s;
    logic            wr_s;
    logic            wr_pend_s;
    logic            wr_mask_s;
    logic            wr_edge_s;
    logic            unused_s;

`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] sync1_r;

    // First synchronizer stage for asynchronous sources.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= {NSRC{1'b0}};
        end else begin
            sync1_r <= src;
        end
    end

    assign s_in_s = sync1_r;
`else
    assign s_in_s = src;
`endif

    assign primed_s  = (prime_cnt_r == PRIME_CYC);
    assign wr_s      = sel & we;
    assign wr_pend_s = wr_s & (addr[3:2] == 2'd0);
    assign wr_mask_s = wr_s & (addr[3:2] == 2'd1);
    assign wr_edge_s = wr_s & (addr[3:2] == 2'd2);
    assign unused_s  = ^{addr[1:0], wdata};

    // Sample path. Until the pipeline refills after reset, s_prev_r tracks the
    // incoming value so that a source already high does not appear as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q_r       <= {NSRC{1'b0}};
            s_prev_r    <= {NSRC{1'b0}};
            prime_cnt_r <= 2'd0;
        end else begin
            s_q_r <= s_in_s;
            if (primed_s) begin
                s_prev_r    <= s_q_r;
                prime_cnt_r <= prime_cnt_r;
            end else begin
                s_prev_r    <= s_in_s;
                prime_cnt_r <= prime_cnt_r + 2'd1;
            end
        end
    end

    // Next pending state: level bits follow s_q_r; edge bits set on a rising
    // edge, and a set beats a simultaneous write-1-to-clear.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 0; i < NSRC; i++) begin
            if (edge_r[i]) begin
                pend_nxt_s[i] = (s_q_r[i] & ~s_prev_r[i]) |
                                (pend_r[i] & ~(wr_pend_s & wdata[i]));
            end else begin
                pend_nxt_s[i] = s_q_r[i];
            end
        end
    end

    // Pending, mask and edge-mode registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r <= {NSRC{1'b0}};
            mask_r <= {NSRC{1'b0}};
            edge_r <= {NSRC{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
            if (wr_mask_s) begin
                mask_r <= wdata[NSRC-1:0];
            end else begin
                mask_r <= mask_r;
            end
            if (wr_edge_s) begin
                edge_r <= wdata[NSRC-1:0];
            end else begin
                edge_r <= edge_r;
            end
        end
    end

    // Registered interrupt vector to the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hw_int <= {NSRC{1'b0}};
        end else begin
            hw_int <= pend_r & mask_r;
        end
    end

    // Combinational read mux, zero when the window is not selected.
    always_comb begin
        rdata = 32'h0000_0000;
        if (sel) begin
            case (addr[3:2])
                2'd0:    rdata = {{(32 - NSRC){1'b0}}, pend_r};
                2'd1:    rdata = {{(32 - NSRC){1'b0}}, mask_r};
                2'd2:    rdata = {{(32 - NSRC){1'b0}}, edge_r};
                2'd3:    rdata = find_id(pend_r & mask_r);
                default: rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

endmodule

// File: doc/intc_hwint.md
# intc_hwint

Memory-mapped interrupt controller that collects external peripheral interrupt sources and produces the CPU's `hwInt` vector. It latches edge-type requests, masks them, and reports the highest-priority pending source. Software accesses it through the CPU data bus via the system bridge, which decodes the address and drives `sel`. Its `hw_int` output connects directly to the CPU `hwInt[5:0]` input.

## Interface
- `NSRC`, default 6: number of interrupt sources; legal range 1..16.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `src` input NSRC: raw interrupt request lines from peripherals.
- `sel` input 1: bridge decode hit for this block's 16-byte window.
- `addr` input 4: byte offset in the window; only `addr[3:2]` is used.
- `we` input 1: write strobe, qualified by `sel`; writes are full-word only.
- `wdata` input 32: write data.
- `rdata` output 32: combinational read data, valid whenever `sel` is high and zero otherwise.
- `hw_int` output NSRC: registered vector `pend & mask`, feeding CPU `hwInt`.

## Operation
- Registers are selected by `addr[3:2]`. All bits at or above NSRC read as 0 and ignore writes.
  - 0 PEND: read; write-1-to-clear, applies to edge-mode bits only.
  - 1 MASK: read/write; 1 enables the source.
  - 2 EDGE: read/write; 1 selects rising-edge mode, 0 selects level mode.
  - 3 ID: read-only; index of the lowest-numbered bit of `pend & mask`, or 32'hFFFF_FFFF if none. Bit 0 has highest priority.
- Sample path: `src` is registered into `s_q`, either directly or through a synchronizer (see Configuration). `s_prev` holds `s_q` delayed by one cycle.
- Level-mode bit: `pend[i] <= s_q[i]` every cycle. W1C has no effect on it.
- Edge-mode bit:
  - Set when `s_q[i] & ~s_prev[i]`.
  - Cleared by a write of 1 to PEND bit i.
  - If set and clear occur in the same cycle, set wins.
  - Stays set while its MASK bit is 0, so the request is never lost.
- Writing EDGE from 1 to 0: the bit becomes level mode next cycle and `pend` follows `s_q` from then on.
- Writing EDGE from 0 to 1: `pend` holds its current value and thereafter follows edge rules.
- `hw_int <= pend & mask` each cycle. The output is registered, so MASK changes reach `hw_int` one cycle after the write edge.
- Writes with `sel=0` or `we=0` are ignored. Writes to ID are ignored.
- Reset (asynchronous, any time, including mid-request) clears `s_q`, `s_prev`, synchronizer flops, `pend`, `mask`, `edge` and `hw_int` to 0. Edges seen before reset are discarded. After release, a source held high in edge mode is not seen as an edge, because `s_prev` loads 1 along with `s_q`.

## Timing
- Register write: takes effect at the rising edge where `sel & we` is high.
- Register read: `rdata` is combinational from current register state, with zero wait states. A read of PEND in the same cycle as a W1C write returns the pre-write value.
- `src` rising, with `INTC_SYNC_EN`:
  - edge 0: sync1
  - edge 1: `s_q`
  - edge 2: `pend`
  - edge 3: `hw_int`
  - Latency is 4 edges.
- `src` rising, without `INTC_SYNC_EN`:
  - edge 0: `s_q`
  - edge 1: `pend`
  - edge 2: `hw_int`
  - Latency is 3 edges.
- W1C of an edge bit: `pend` clears at the write edge; `hw_int` drops at the next edge.
- Minimum detectable pulse: one `clk` period high followed by one low, both captured at `s_q`.

## Configuration
- `INTC_SYNC_EN` defined:
  - A two-flop synchronizer on each `src` bit ahead of `s_q`.
  - Use for sources from other clock domains.
- `INTC_SYNC_EN` undefined:
  - Single sample flop only.
  - `src` must be synchronous to `clk`.
  - Latency is one cycle shorter.

## Test plan
- Reset: deassert `reset` with `src=6'h3F`. Expect `hw_int=0`, MASK/EDGE/PEND read 0, and ID reads 32'hFFFF_FFFF.
- Level source: EDGE=0, MASK=6'h04, raise `src[2]`.
  - Expect `hw_int=6'h04` after the stated latency and ID=2.
  - Drop `src[2]`; expect `hw_int=0` after the same latency.
- Edge latch with mask: EDGE=6'h3F, MASK=0, 1-cycle pulse on `src[5]`.
  - Expect PEND=6'h20 and `hw_int=0`.
  - Write MASK=6'h20; expect `hw_int=6'h20` next edge.
  - Write PEND=6'h20; expect PEND=0, then `hw_int=0` one edge later.
- Priority: edge pulses on `src[1]` and `src[4]`, MASK=6'h3F.
  - Expect ID=1.
  - W1C bit 1; expect ID=4.
- Set/clear collision: W1C bit 3 in the same cycle a new edge on bit 3 reaches `s_q`. Expect PEND bit 3 to remain 1.
- Reset mid-operation: PEND=6'h0A pending, assert `reset` asynchronously between clock edges.
  - Expect `hw_int=0` immediately and all registers 0.
  - After release with `src[1]` held high in edge mode, expect no new pend.
